// File: rtl/i2c_slave_responder.sv
// I2C target: START/Sr/STOP decode, 7-bit address match with ACK, write bytes out on an
// rx pulse, read bytes in from a tx handshake with optional SCL stretching.
module i2c_slave_responder #(
  parameter logic [6:0] SLV_ADDR    = 7'h22,
  parameter bit         STRETCH_EN  = 1'b1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic [3:0] state_o
);

  // Handshakes: rx_valid_o is a one-cycle pulse qualifying rx_data_o; rx_ready_i is sampled
  // at the 8th SCL rise and decides ACK (1) or NACK/drop (0). tx_valid_i=1 offers tx_data_i;
  // the byte is taken when in RD_LOAD, and tx_ready_o pulses in the following cycle, so a
  // source keeps tx_data_i stable until it observes tx_ready_o.

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK,
    S_RD_LOAD, S_RD_DATA, S_RD_ACKCHK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_d, sda_d, scl_s, sda_s;
  logic scl_rise, scl_fall, start_c, stop_c;

  // Synchronizers reset to the idle-bus level so reset release creates no false condition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;

  state_t     state_q, state_n;
  logic [3:0] bit_cnt_q, bit_cnt_n, cnt_inc;
  logic [7:0] shreg_q, shreg_n, rx_data_n;
  logic       rw_q, rw_n, rx_acc_q, rx_acc_n, mack_q, mack_n;
  logic       sda_n, scl_n, rx_valid_n, tx_ready_n, start_n, stop_n, busy_n;

  assign cnt_inc = (bit_cnt_q == 4'd9) ? bit_cnt_q : bit_cnt_q + 4'd1;
  assign state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rw_q       <= 1'b0;
      rx_acc_q   <= 1'b0;
      mack_q     <= 1'b0;
      sda_o      <= 1'b0;
      scl_o      <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      shreg_q    <= shreg_n;
      rw_q       <= rw_n;
      rx_acc_q   <= rx_acc_n;
      mack_q     <= mack_n;
      sda_o      <= sda_n;
      scl_o      <= scl_n;
      rx_data_o  <= rx_data_n;
      rx_valid_o <= rx_valid_n;
      tx_ready_o <= tx_ready_n;
      start_o    <= start_n;
      stop_o     <= stop_n;
      busy_o     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    shreg_n    = shreg_q;
    rw_n       = rw_q;
    rx_acc_n   = rx_acc_q;
    mack_n     = mack_q;
    sda_n      = sda_o;
    scl_n      = scl_o;
    rx_data_n  = rx_data_o;
    rx_valid_n = 1'b0;
    tx_ready_n = 1'b0;
    start_n    = 1'b0;
    stop_n     = 1'b0;
    busy_n     = busy_o;

    case (state_q)
      S_IDLE: ;
      S_ADDR: begin
        if (scl_rise) begin
          shreg_n   = {shreg_q[6:0], sda_s};
          bit_cnt_n = cnt_inc;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          bit_cnt_n = '0;
          if (shreg_q[7:1] == SLV_ADDR) begin
            state_n = S_ADDR_ACK;
            sda_n   = 1'b1;
            rw_n    = shreg_q[0];
          end else begin
            state_n = S_IGNORE;
          end
        end
      end
      S_ADDR_ACK: begin
        if (scl_fall) begin
          sda_n     = 1'b0;
          bit_cnt_n = '0;
          state_n   = rw_q ? S_RD_LOAD : S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (scl_rise) begin
          shreg_n   = {shreg_q[6:0], sda_s};
          bit_cnt_n = cnt_inc;
          if (bit_cnt_q == 4'd7) begin
            rx_acc_n = rx_ready_i;
            if (rx_ready_i) begin
              rx_data_n  = {shreg_q[6:0], sda_s};
              rx_valid_n = 1'b1;
            end
          end
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          state_n   = S_WR_ACK;
          sda_n     = rx_acc_q;
          bit_cnt_n = '0;
        end
      end
      S_WR_ACK: begin
        if (scl_fall) begin
          sda_n   = 1'b0;
          state_n = S_WR_DATA;
        end
      end
      S_RD_LOAD: begin
        if (tx_valid_i) begin
          shreg_n    = tx_data_i;
          tx_ready_n = 1'b1;
          sda_n      = ~tx_data_i[7];
          scl_n      = 1'b0;
          bit_cnt_n  = '0;
          state_n    = S_RD_DATA;
        end else if (STRETCH_EN) begin
          scl_n = 1'b1;
        end else begin
          shreg_n   = 8'hFF;
          sda_n     = 1'b0;
          bit_cnt_n = '0;
          state_n   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (scl_rise) begin
          bit_cnt_n = cnt_inc;
        end else if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_n     = 1'b0;
            bit_cnt_n = '0;
            state_n   = S_RD_ACKCHK;
          end else begin
            shreg_n = {shreg_q[6:0], 1'b0};
            sda_n   = ~shreg_q[6];
          end
        end
      end
      S_RD_ACKCHK: begin
        if (scl_rise) mack_n = sda_s;
        else if (scl_fall) state_n = mack_q ? S_IGNORE : S_RD_LOAD;
      end
      S_IGNORE: begin
        sda_n = 1'b0;
        scl_n = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase

    // Bus conditions win over any bit event; a pending rx pulse is left to fire.
    if (start_c) begin
      state_n    = S_ADDR;
      bit_cnt_n  = '0;
      sda_n      = 1'b0;
      scl_n      = 1'b0;
      tx_ready_n = 1'b0;
      start_n    = 1'b1;
      busy_n     = 1'b1;
    end else if (stop_c) begin
      state_n    = S_IDLE;
      bit_cnt_n  = '0;
      sda_n      = 1'b0;
      scl_n      = 1'b0;
      tx_ready_n = 1'b0;
      stop_n     = 1'b1;
      busy_n     = 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged open-drain master, transaction-level target
// model, and an rx scoreboard popped by a monitor on rx_valid_o.
module tb_i2c_slave_responder;
  localparam int         H    = 12;
  localparam logic [6:0] ADDR = 7'h22;

  logic       clk = 1'b0;
  logic       rst_i, scl_m, sda_m, scl_bus, sda_bus;
  logic       scl_o, sda_o, rx_valid_o, rx_ready_i, tx_valid_i, tx_ready_o;
  logic       start_o, stop_o, busy_o, tx_hold;
  logic [7:0] rx_data_o, tx_data_i, rd_d;
  logic [3:0] state_o;

  assign scl_bus = scl_m & ~scl_o;
  assign sda_bus = sda_m & ~sda_o;

  i2c_slave_responder #(.SLV_ADDR(ADDR), .STRETCH_EN(1'b1), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_o(scl_o), .sda_o(sda_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .start_o(start_o), .stop_o(stop_o), .busy_o(busy_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int start_cnt = 0, stop_cnt = 0, txr_cnt = 0;
  int exp_start = 0, exp_stop = 0, exp_txr = 0;
  int ok, s0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] tx_src_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release SCL and wait (bounded) for any stretching to end.
  task automatic scl_release();
    int cnt;
    cnt   = 0;
    scl_m = 1'b1;
    while (scl_bus !== 1'b1 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 5000) begin
      checks++;
      errors++;
      $display("FAIL scl_release: SCL still low after %0d clk, expected release", cnt);
    end
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    wait_clk(H / 2);
    scl_release();
    wait_clk(H);
    scl_m = 1'b0;
    wait_clk(H / 2);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1;
    wait_clk(H / 2);
    scl_release();
    wait_clk(H / 2);
    b = sda_bus;
    wait_clk(H / 2);
    scl_m = 1'b0;
    wait_clk(H / 2);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b0;
    wait_clk(H / 2);
    exp_start++;
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1;
    wait_clk(H / 2);
    scl_release();
    wait_clk(H);
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b0;
    wait_clk(H / 2);
    exp_start++;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(H / 2);
    scl_release();
    wait_clk(H);
    sda_m = 1'b1;
    wait_clk(H);
    exp_stop++;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~master_ack);
  endtask

  // Model: address ACK iff it equals ADDR; a data byte is ACKed and delivered iff rx_ready_i=1.
  task automatic do_write(input logic [6:0] a, input int n, input logic [7:0] b[4],
                          input logic r[4], input bit rstart, input bit do_stop);
    logic ack;
    if (rstart) i2c_rstart(); else i2c_start();
    write_byte({a, 1'b0}, ack);
    check("wr_addr_ack", ack, a == ADDR);
    if (a == ADDR) begin
      for (int k = 0; k < n; k++) begin
        rx_ready_i = r[k];
        if (r[k]) exp_q.push_back(b[k]);
        write_byte(b[k], ack);
        check("wr_data_ack", ack, r[k]);
      end
    end
    rx_ready_i = 1'b1;
    if (do_stop) i2c_stop();
  endtask

  // Model: a matched read returns the offered tx bytes in order, one tx_ready_o each.
  task automatic do_read(input logic [6:0] a, input int n, input logic [7:0] b[4],
                         input bit rstart);
    logic ack;
    logic [7:0] d;
    if (a == ADDR) begin
      for (int k = 0; k < n; k++) begin
        tx_src_q.push_back(b[k]);
        exp_rd_q.push_back(b[k]);
      end
      exp_txr += n;
    end
    if (rstart) i2c_rstart(); else i2c_start();
    write_byte({a, 1'b1}, ack);
    check("rd_addr_ack", ack, a == ADDR);
    if (a == ADDR) begin
      for (int k = 0; k < n; k++) begin
        read_byte(k != n - 1, d);
        check("rd_byte", d, exp_rd_q.pop_front());
      end
    end
    i2c_stop();
  endtask

  // tx source: presents the head of tx_src_q, retires it when tx_ready_o is seen.
  initial begin
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_ready_o && tx_src_q.size() > 0) void'(tx_src_q.pop_front());
      if (!tx_hold && tx_src_q.size() > 0) begin
        tx_valid_i = 1'b1;
        tx_data_i  = tx_src_q[0];
      end else begin
        tx_valid_i = 1'b0;
      end
    end
  end

  // Monitor: pops the rx scoreboard on each rx_valid_o and counts event pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (rx_valid_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got byte 0x%0h, expected no rx_valid_o", rx_data_o);
          end else begin
            check("rx_data", rx_data_o, exp_q.pop_front());
          end
        end
        if (start_o) start_cnt++;
        if (stop_o) stop_cnt++;
        if (tx_ready_o) txr_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack, b;
    logic [7:0] rb[4];
    logic rr[4];
    logic [6:0] a;
    int n;
    rst_i = 1'b1; rx_ready_i = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_hold = 1'b0;
    wait_clk(5);
    check("reset_outputs", {scl_o, sda_o, rx_valid_o, tx_ready_o, start_o, stop_o, busy_o,
                            rx_data_o, state_o}, 0);
    rst_i = 1'b0;
    wait_clk(5);

    do_write(ADDR, 2, '{8'hA5, 8'h3C, 8'h00, 8'h00}, '{1'b1, 1'b1, 1'b0, 1'b0}, 0, 1);
    wait_clk(5);
    check("write_rx_drained", exp_q.size(), 0);
    check("write_stop_count", stop_cnt, 1);

    do_write(7'h23, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, '{1'b0, 1'b0, 1'b0, 1'b0}, 0, 0);
    check("nack_busy", busy_o, 1);
    wait_clk(50);
    check("nack_busy_hold", busy_o, 1);
    i2c_stop();
    check("nack_busy_after_stop", busy_o, 0);

    do_read(ADDR, 2, '{8'h81, 8'h7E, 8'h00, 8'h00}, 0);

    // Stretch: no tx data for 500 clk after the address ACK.
    tx_hold = 1'b1;
    i2c_start();
    write_byte({ADDR, 1'b1}, ack);
    check("stretch_addr_ack", ack, 1);
    fork
      read_byte(1'b0, rd_d);
      begin
        ok = 1;
        repeat (500) begin
          @(negedge clk);
          if (scl_o !== 1'b1) ok = 0;
        end
        check("stretch_window", ok, 1);
        tx_src_q.push_back(8'h55);
        exp_txr++;
        tx_hold = 1'b0;
      end
    join
    check("stretch_byte", rd_d, 8'h55);
    i2c_stop();

    s0 = start_cnt;
    do_write(ADDR, 1, '{8'h10, 8'h00, 8'h00, 8'h00}, '{1'b1, 1'b0, 1'b0, 1'b0}, 0, 0);
    do_read(ADDR, 1, '{8'hC3, 8'h00, 8'h00, 8'h00}, 1);
    check("sr_start_pulses", start_cnt - s0, 2);

    do_write(ADDR, 1, '{8'h99, 8'h00, 8'h00, 8'h00}, '{1'b0, 1'b0, 1'b0, 1'b0}, 0, 1);

    // Reset in the middle of a read while the target drives a 0 bit.
    tx_src_q.push_back(8'h00);
    exp_txr++;
    i2c_start();
    write_byte({ADDR, 1'b1}, ack);
    check("rst_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) recv_bit(b);
    check("rst_pre_bit", b, 0);
    wait_clk(2);
    check("rst_pre_drive", sda_o, 1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("rst_lines_released", {scl_o, sda_o}, 2'b00);
    wait_clk(2);
    rst_i = 1'b0;
    wait_clk(4);
    i2c_stop();

    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, 4);
      a = ($urandom_range(0, 3) == 0) ? (ADDR ^ 7'($urandom_range(1, 127))) : ADDR;
      for (int k = 0; k < 4; k++) begin
        rb[k] = 8'($urandom);
        rr[k] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 1) == 0) do_write(a, n, rb, rr, 0, 1);
      else do_read(a, n, rb, 0);
    end

    wait_clk(10);
    check("final_rx_drained", exp_q.size(), 0);
    check("final_start_count", start_cnt, exp_start);
    check("final_stop_count", stop_cnt, exp_stop);
    check("final_tx_ready_count", txr_cnt, exp_txr);
    check("final_busy", busy_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
